// File: rtl/seq_subtractor32.sv
// seq_subtractor32: multi-cycle subtractor computing d = x - y - bin one
// SLICE_W-bit slice per clock, least-significant slice first, with the borrow
// rippling between slices. Result and flags (borrow-out, zero, signed
// overflow) are published only when the last slice completes, so partial
// differences never appear on the outputs.
module seq_subtractor32 #(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] acc_q;
  logic             borrow_q;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             zero_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic [SLICE_W-1:0] xs_s;
  logic [SLICE_W-1:0] ys_s;
  logic [SLICE_W:0]   diff_s;
  logic [WIDTH-1:0]   acc_d;
  logic               zero_d;
  logic               ovf_d;

  // Current slice subtraction and the accumulator with that slice filled in.
  always_comb begin
    xs_s   = x_q[int'(cnt_q) * SLICE_W +: SLICE_W];
    ys_s   = y_q[int'(cnt_q) * SLICE_W +: SLICE_W];
    diff_s = {1'b0, xs_s} - {1'b0, ys_s} - {{SLICE_W{1'b0}}, borrow_q};
    acc_d  = acc_q;
    acc_d[int'(cnt_q) * SLICE_W +: SLICE_W] = diff_s[SLICE_W-1:0];
    // Flags derive from the captured operands and the completed difference.
    zero_d = (acc_d == {WIDTH{1'b0}});
    ovf_d  = (x_q[WIDTH-1] != y_q[WIDTH-1]) && (acc_d[WIDTH-1] != x_q[WIDTH-1]);
  end

  // Control FSM, operand capture, slice datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      x_q      <= {WIDTH{1'b0}};
      y_q      <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      borrow_q <= 1'b0;
      d_q      <= {WIDTH{1'b0}};
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // DONE accepts a new start exactly like IDLE, giving back-to-back ops.
        S_IDLE, S_DONE: begin
          if (start) begin
            x_q      <= x;
            y_q      <= y;
            borrow_q <= bin;
            cnt_q    <= {CNT_W{1'b0}};
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        // start is deliberately not looked at here.
        S_RUN: begin
          acc_q    <= acc_d;
          borrow_q <= diff_s[SLICE_W];
          if (cnt_q == LAST_CNT) begin
            cnt_q   <= {CNT_W{1'b0}};
            d_q     <= acc_d;
            bout_q  <= diff_s[SLICE_W];
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q   <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_q <= S_RUN;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bout = bout_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_subtractor32.sv
// Testbench for seq_subtractor32: table of vectors with a scoreboard queue,
// plus hand-written protocol and mid-operation reset sequences.
module tb_seq_subtractor32;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        bin;
    logic [31:0] ed;
    logic        eb;
    logic        ez;
    logic        eo;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] x;
  logic [31:0] y;
  logic        bin;
  logic        busy;
  logic        done;
  logic [31:0] d;
  logic        bout;
  logic        zero;
  logic        ovf;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int pushed   = 0;
  logic [31:0] last_d = 32'd0;
  vec_t exp_q[$];
  vec_t tbl[12];

  seq_subtractor32 dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .bin(bin),
    .busy(busy), .done(done), .d(d), .bout(bout), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model built on 33-bit arithmetic.
  function automatic vec_t model(input logic [31:0] a, input logic [31:0] b, input logic c);
    vec_t v;
    logic [32:0] w;
    w    = {1'b0, a} - {1'b0, b} - {32'd0, c};
    v.x  = a;
    v.y  = b;
    v.bin = c;
    v.ed = w[31:0];
    v.eb = w[32];
    v.ez = (w[31:0] == 32'd0);
    v.eo = (a[31] != b[31]) && (w[31] != a[31]);
    return v;
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic c,
                              input logic [31:0] ed, input logic eb, input logic ez, input logic eo);
    vec_t v;
    v.x = a; v.y = b; v.bin = c; v.ed = ed; v.eb = eb; v.ez = ez; v.eo = eo;
    return v;
  endfunction

  // Scoreboard: every done pulse pops and checks one expected result.
  always @(negedge clk) begin
    vec_t e;
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("d", d, e.ed);
        chk("bout", {31'd0, bout}, {31'd0, e.eb});
        chk("zero", {31'd0, zero}, {31'd0, e.ez});
        chk("ovf", {31'd0, ovf}, {31'd0, e.eo});
      end
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 20);
    if (done !== 1'b1) chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  // One full operation with latency, busy and output-hold checks.
  task automatic do_vec(input vec_t v);
    @(negedge clk);
    x = v.x; y = v.y; bin = v.bin; start = 1'b1;
    exp_q.push_back(v);
    pushed++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      x = ~v.x; y = ~v.y; bin = ~v.bin;
      chk("busy_run", {31'd0, busy}, 32'd1);
      chk("done_early", {31'd0, done}, 32'd0);
      chk("d_hold_run", d, last_d);
    end
    @(negedge clk);
    chk("done_lat", {31'd0, done}, 32'd1);
    chk("busy_done", {31'd0, busy}, 32'd0);
    last_d = v.ed;
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("d_hold_idle", d, last_d);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; x = 32'd0; y = 32'd0; bin = 1'b0;

    tbl[0]  = mk(32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0);
    tbl[1]  = mk(32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    tbl[2]  = mk(32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);
    tbl[3]  = mk(32'h80000000, 32'h00000000, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);
    tbl[4]  = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    tbl[5]  = mk(32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    tbl[6]  = mk(32'h00010000, 32'h00000001, 1'b0, 32'h0000FFFF, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b1);
    for (int i = 8; i < 12; i++)
      tbl[i] = model($urandom, $urandom, 1'($urandom_range(0, 1)));

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_d", d, 32'd0);
    chk("rst_flags", {29'd0, bout, zero, ovf}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) do_vec(tbl[i]);

    // Start during RUN is ignored; back-to-back start in the DONE cycle.
    @(negedge clk);
    x = 32'h00000100; y = 32'h00000001; bin = 1'b0; start = 1'b1;
    exp_q.push_back(mk(32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, 1'b0, 1'b0));
    pushed++;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    x = 32'hDEADBEEF; y = 32'h12345678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk("a_latency", n, 32'd2);
    x = 32'd5; y = 32'd5; bin = 1'b0; start = 1'b1;
    exp_q.push_back(mk(32'd5, 32'd5, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0));
    pushed++;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_d_hold", d, 32'h000000FF);
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("b2b_done", {31'd0, done}, 32'd1);
    repeat (6) @(negedge clk);

    // Reset in the second RUN cycle aborts the operation.
    x = 32'd1; y = 32'd2; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_d", d, 32'd0);
    chk("abort_flags", {29'd0, bout, zero, ovf}, 32'd0);
    last_d = 32'd0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort_no_done", {31'd0, done}, 32'd0);
    end
    do_vec(mk(32'd10, 32'd3, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0));

    repeat (3) @(negedge clk);
    chk("done_count", done_cnt, pushed);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_subtractor32.md
Name: seq_subtractor32

Overview:
- Multi-cycle unsigned/two's-complement subtractor; the inverse operation of the team's 32-bit ripple adder.
- Computes d = x - y - bin one SLICE_W-bit slice per clock, least-significant slice first, with the borrow rippling between slices.
- Reports borrow-out, zero and signed-overflow flags.
- Used wherever an area-cheap subtract or compare is needed and a few cycles of latency are acceptable.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SLICE_W, 8, bits processed per cycle. WIDTH must be an integer multiple of SLICE_W.
- NSLICE = WIDTH/SLICE_W is a derived constant (4 at defaults), not a parameter.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only as specified under Behaviour.
- x  input  WIDTH  minuend; captured on an accepted start.
- y  input  WIDTH  subtrahend; captured on an accepted start.
- bin  input  1  borrow-in; captured on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result and flags are valid.
- d  output  WIDTH  difference, x - y - bin mod 2^WIDTH.
- bout  output  1  final borrow-out; 1 iff x < y + bin (unsigned).
- zero  output  1  1 iff d == 0.
- ovf  output  1  signed overflow of x - y - bin.

Behaviour:
- Reset (rst=1 at a rising edge):
  - State returns to IDLE; slice counter cleared.
  - Internal operand, accumulator and borrow registers cleared.
  - busy, done, d, bout, zero and ovf all read 0 after that edge.
  - rst has priority over start.
- States are IDLE, RUN and DONE.
- IDLE:
  - start=1 at an edge: capture x, y and bin; set cnt=0 and the running borrow to bin; go to RUN.
  - start=0: remain in IDLE.
- RUN:
  - At each edge, compute {b, r} = x[slice cnt] - y[slice cnt] - borrow using SLICE_W+1-bit arithmetic.
  - Write r into accumulator slice cnt, set borrow=b, and increment cnt.
  - At the edge that processes slice NSLICE-1:
    - load d from the complete accumulator and set bout = final b;
    - set zero = (d == 0) and ovf = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]), both from the captured operands;
    - go to DONE.
  - start is ignored throughout RUN; captured operands are unaffected by input changes.
- DONE:
  - done=1 for exactly this one cycle.
  - start=1 at the edge: accept a new operation as in IDLE and go to RUN (back-to-back operation allowed).
  - Otherwise go to IDLE.
- Latency: start accepted at edge N, then RUN for NSLICE edges (N+1..N+NSLICE), then done=1 in the cycle after edge N+NSLICE. At defaults done is high after edge N+4; throughput is one result per 5 cycles.
- d, bout, zero and ovf update only at completion. They hold the last result through IDLE and through the next RUN; partial results are never visible on the outputs.
- Wrap-around: the result is always mod 2^WIDTH. x=0, y=0, bin=1 gives d = all ones and bout=1.
- Reset mid-RUN: the operation is aborted, done is never asserted for it, outputs read 0, and the next start behaves normally.

Test Plan:
- Reset then x=0, y=0, bin=0, start pulse:
  - busy high for 4 cycles, done pulse in the 5th cycle after start;
  - d=0x00000000, bout=0, zero=1, ovf=0.
- x=0x00000000, y=0x00000001, bin=0 -> d=0xFFFFFFFF, bout=1, zero=0, ovf=0. Checks the borrow ripple across all four slices.
- Overflow cases:
  - x=0x80000000, y=0x00000001, bin=0 -> d=0x7FFFFFFF, bout=0, ovf=1.
  - x=0x80000000, y=0, bin=1 -> d=0x7FFFFFFF, ovf=1.
- x=0xFFFFFFFF, y=0xFFFFFFFF, bin=1 -> d=0xFFFFFFFF, bout=1, ovf=0, zero=0.
- Protocol checks:
  - Start op A (x=0x00000100, y=0x00000001); during RUN, pulse start with different x/y. Required: single done, d=0x000000FF, no second operation.
  - Then hold start high in the DONE cycle with x=5, y=5. Required: new op accepted immediately, next done gives d=0, zero=1.
- Assert rst for one cycle at the 2nd RUN cycle:
  - no done pulse; busy and all outputs read 0 on the following cycle;
  - a subsequent start with x=10, y=3 gives d=7 after the full latency.
